// File: rtl/reg_bank_write_sched.sv
// Write-port scheduler for a register bank: round-robin arbitration between
// requesters, plus a clear sweep after reset or on clear_req.
module reg_bank_write_sched #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned ADDR_W      = 3,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned NUM_REGS    = 8,
  parameter int unsigned CLEAR_VALUE = 0
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  input  logic                        clear_req,
  output logic                        clear_busy,
  output logic                        wr_en,
  output logic [ADDR_W-1:0]           wr_addr,
  output logic [DATA_W-1:0]           wr_data,
  output logic [2:0]                  wr_src,
  output logic                        wr_is_clear
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned PAD_W = 1 << PTR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);
  localparam logic [DATA_W-1:0] CLR_DATA  = DATA_W'(CLEAR_VALUE);
  localparam logic [PTR_W-1:0]  LAST_REQ  = PTR_W'(NUM_REQ - 1);

  typedef enum logic {ST_CLEAR, ST_ARB} state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_sweep_cnt;
  logic [PTR_W-1:0]    r_rr_ptr;
  logic                r_wr_en;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [DATA_W-1:0]   r_wr_data;
  logic [2:0]          r_wr_src;
  logic                r_wr_is_clear;

  logic [PAD_W-1:0]    w_valid_pad;
  logic [31:0]         w_sum;
  logic [PTR_W-1:0]    w_idx;
  logic                w_found;
  logic [PTR_W-1:0]    w_winner;
  logic [PTR_W-1:0]    w_next_ptr;
  logic                w_grant;
  logic [ADDR_W-1:0]   w_win_addr;
  logic [DATA_W-1:0]   w_win_data;

  // First valid requester at or after the round-robin pointer, wrapping.
  always_comb begin
    w_valid_pad = PAD_W'(req_valid);
    w_sum       = '0;
    w_idx       = '0;
    w_found     = 1'b0;
    w_winner    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_sum = (32'(r_rr_ptr) + k) % NUM_REQ;
      w_idx = PTR_W'(w_sum);
      if (!w_found && w_valid_pad[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  assign w_grant    = (r_state == ST_ARB) && !clear_req && w_found;
  assign w_next_ptr = (w_winner == LAST_REQ) ? '0 : w_winner + PTR_W'(1);
  assign clear_busy = (r_state == ST_CLEAR);

  always_comb begin
    req_ready  = '0;
    w_win_addr = '0;
    w_win_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (PTR_W'(i) == w_winner) begin
        req_ready[i] = w_grant;
        w_win_addr   = req_addr[i*ADDR_W +: ADDR_W];
        w_win_data   = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_CLEAR;
      r_sweep_cnt   <= '0;
      r_rr_ptr      <= '0;
      r_wr_en       <= 1'b0;
      r_wr_addr     <= '0;
      r_wr_data     <= '0;
      r_wr_src      <= '0;
      r_wr_is_clear <= 1'b0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          r_wr_en       <= 1'b1;
          r_wr_addr     <= r_sweep_cnt;
          r_wr_data     <= CLR_DATA;
          r_wr_src      <= '0;
          r_wr_is_clear <= 1'b1;
          if (r_sweep_cnt == LAST_ADDR) begin
            r_state     <= ST_ARB;
            r_sweep_cnt <= '0;
          end else begin
            r_sweep_cnt <= r_sweep_cnt + ADDR_W'(1);
          end
        end
        ST_ARB: begin
          r_wr_en       <= w_grant;
          r_wr_is_clear <= 1'b0;
          if (clear_req) begin
            r_state <= ST_CLEAR;
          end else if (w_grant) begin
            r_wr_addr <= w_win_addr;
            r_wr_data <= w_win_data;
            r_wr_src  <= 3'(w_winner);
            r_rr_ptr  <= w_next_ptr;
          end
        end
      endcase
    end
  end

  assign wr_en       = r_wr_en;
  assign wr_addr     = r_wr_addr;
  assign wr_data     = r_wr_data;
  assign wr_src      = r_wr_src;
  assign wr_is_clear = r_wr_is_clear;

endmodule

// File: tb/tb_reg_bank_write_sched.sv
// Scoreboard bench for reg_bank_write_sched: a cycle model predicts req_ready
// and the next bank write, which is queued and compared after the clock edge.
module tb_reg_bank_write_sched;

  localparam int NR    = 4;
  localparam int AW    = 3;
  localparam int DW    = 8;
  localparam int NREGS = 8;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_data;
  logic              clear_req;
  logic              clear_busy;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic [2:0]        wr_src;
  logic              wr_is_clear;

  always #5 clk = ~clk;

  reg_bank_write_sched #(
    .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .NUM_REGS(NREGS), .CLEAR_VALUE(0)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data),
    .clear_req(clear_req), .clear_busy(clear_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_src(wr_src), .wr_is_clear(wr_is_clear)
  );

  typedef struct packed {
    logic        en;
    logic [2:0]  addr;
    logic [7:0]  data;
    logic [2:0]  src;
    logic        clr;
  } wr_exp_t;

  wr_exp_t    exp_q[$];
  int         n_checks = 0;
  int         n_errors = 0;

  bit         m_clear;
  int         m_cnt;
  int         m_ptr;
  logic [2:0] m_addr;
  logic [7:0] m_data;
  logic [2:0] m_src;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_clear = 1'b1;
    m_cnt   = 0;
    m_ptr   = 0;
    m_addr  = '0;
    m_data  = '0;
    m_src   = '0;
    exp_q.delete();
  endtask

  // Inputs are already driven; predict this cycle, clock it, compare the write.
  task automatic step();
    wr_exp_t       e;
    wr_exp_t       got;
    logic [NR-1:0] exp_ready;
    int            win;
    #1;
    exp_ready = '0;
    e         = '0;
    e.addr    = m_addr;
    e.data    = m_data;
    e.src     = m_src;
    check_val("clear_busy", 32'(clear_busy), 32'(m_clear));
    if (m_clear) begin
      e.en   = 1'b1;
      e.addr = 3'(m_cnt);
      e.data = 8'h00;
      e.src  = 3'd0;
      e.clr  = 1'b1;
      if (m_cnt == NREGS - 1) begin
        m_clear = 1'b0;
        m_cnt   = 0;
      end else begin
        m_cnt++;
      end
    end else if (clear_req) begin
      m_clear = 1'b1;
    end else begin
      win = -1;
      for (int k = 0; k < NR; k++) begin
        int c = (m_ptr + k) % NR;
        if (win < 0 && req_valid[c]) win = c;
      end
      if (win >= 0) begin
        exp_ready[win] = 1'b1;
        e.en   = 1'b1;
        e.addr = req_addr[win*AW +: AW];
        e.data = req_data[win*DW +: DW];
        e.src  = 3'(win);
        m_ptr  = (win + 1) % NR;
      end
    end
    if (e.en) begin
      m_addr = e.addr;
      m_data = e.data;
      m_src  = e.src;
    end
    check_val("req_ready", 32'(req_ready), 32'(exp_ready));
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check_val("sb_empty", 32'(1), 32'(0));
    end else begin
      got = exp_q.pop_front();
      check_val("wr_en", 32'(wr_en), 32'(got.en));
      check_val("wr_addr", 32'(wr_addr), 32'(got.addr));
      check_val("wr_data", 32'(wr_data), 32'(got.data));
      check_val("wr_src", 32'(wr_src), 32'(got.src));
      if (got.en) check_val("wr_is_clear", 32'(wr_is_clear), 32'(got.clr));
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_wr_en"}, 32'(wr_en), 32'(0));
    check_val({tag, "_wr_addr"}, 32'(wr_addr), 32'(0));
    check_val({tag, "_wr_data"}, 32'(wr_data), 32'(0));
    check_val({tag, "_wr_src"}, 32'(wr_src), 32'(0));
    check_val({tag, "_wr_is_clear"}, 32'(wr_is_clear), 32'(0));
    check_val({tag, "_clear_busy"}, 32'(clear_busy), 32'(1));
    check_val({tag, "_req_ready"}, 32'(req_ready), 32'(0));
  endtask

  initial begin
    reset_n   = 1'b0;
    req_valid = '1;
    req_addr  = {3'd4, 3'd3, 3'd2, 3'd1};
    req_data  = {8'h44, 8'h33, 8'h22, 8'h11};
    clear_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("rst");

    // Release and idle through the power-on sweep.
    model_reset();
    req_valid = '0;
    reset_n   = 1'b1;
    repeat (NREGS + 1) step();

    // All requesters valid: grants rotate through 0..3 twice.
    req_valid = '1;
    repeat (8) step();

    // Requester 2 alone.
    req_valid = 4'b0100;
    req_addr[2*AW +: AW] = 3'd5;
    req_data[2*DW +: DW] = 8'hA5;
    step();
    req_valid = '0;
    step();

    // Clear request collides with valid requests; clear wins.
    req_valid = 4'b0011;
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    repeat (NREGS) step();
    step();
    req_valid = '0;
    step();

    // Clear held through a sweep triggers a second sweep.
    clear_req = 1'b1;
    repeat (NREGS + 2) step();
    clear_req = 1'b0;
    repeat (NREGS + 1) step();

    // Reset mid-sweep after write to address 4 is visible.
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check_reset_vals("mid");
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (5) step();
    reset_n = 1'b0;
    #1;
    check_reset_vals("sweep4");
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (NREGS + 1) step();

    // Random traffic with occasional clears.
    for (int n = 0; n < 80; n++) begin
      req_valid = NR'($urandom);
      req_addr  = (NR*AW)'($urandom);
      req_data  = {$urandom, $urandom};
      clear_req = ($urandom_range(0, 15) == 0);
      step();
    end
    clear_req = 1'b0;
    req_valid = '0;
    repeat (NREGS + 2) step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/reg_bank_write_sched.md
Name: reg_bank_write_sched

Overview:
- Write-port scheduler for a register bank; the bank is a set of plain clocked registers with reset values.
- Shares the bank's single write port between NUM_REQ requesters, using round-robin arbitration and a valid/ready handshake per requester.
- Runs a clear sweep that writes CLEAR_VALUE to every register:
  - automatically after reset;
  - on request, via clear_req.
- Sits between the requesting units and the register bank write port.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, 3, register address width
DATA_W, 8, register data width
NUM_REGS, 8, registers swept by a clear (1..2**ADDR_W)
CLEAR_VALUE, 0, data written during a clear sweep

Ports:
clk  in  1  sole clock, rising edge
reset_n  in  1  asynchronous, active-low reset
req_valid  in  NUM_REQ  per-requester write request
req_ready  out  NUM_REQ  per-requester accept (combinational)
req_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at bits [i*ADDR_W +: ADDR_W]
req_data  in  NUM_REQ*DATA_W  packed data, requester i at bits [i*DATA_W +: DATA_W]
clear_req  in  1  request a clear sweep (level, sampled in ARB)
clear_busy  out  1  sweep in progress
wr_en  out  1  bank write strobe (registered)
wr_addr  out  ADDR_W  bank write address (registered)
wr_data  out  DATA_W  bank write data (registered)
wr_src  out  3  index of the granted requester for the current write (registered)
wr_is_clear  out  1  current write belongs to a sweep (registered)

Behaviour:
- One clock; reset is asynchronous and active-low (reset_n).
- Reset values:
  - state=CLEAR, sweep_cnt=0, rr_ptr=0;
  - wr_en=0, wr_addr=0, wr_data=0, wr_src=0, wr_is_clear=0;
  - clear_busy=1 (decoded from state).
- States: CLEAR, ARB.
- CLEAR:
  - req_ready all 0.
  - Each cycle, register wr_en=1, wr_addr=sweep_cnt, wr_data=CLEAR_VALUE, wr_is_clear=1, wr_src=0.
  - sweep_cnt increments each cycle.
  - When sweep_cnt==NUM_REGS-1, go to ARB and reset sweep_cnt to 0.
  - clear_req is ignored while in CLEAR and is not queued.
- Sweep timing after reset release: writes to addr 0..NUM_REGS-1 appear on wr_* in cycles 1..NUM_REGS. clear_busy drops, and req_ready may rise, in cycle NUM_REGS.
- ARB with clear_req=1:
  - clear takes priority: no req_ready that cycle, no handshake;
  - next state is CLEAR;
  - the first sweep write appears 2 cycles after clear_req is sampled.
- ARB with clear_req=0:
  - winner = first i with req_valid[i]=1, searching from rr_ptr upward, modulo NUM_REQ;
  - req_ready[winner]=1, all other bits 0; no valid → all 0;
  - handshake = req_valid & req_ready;
  - next cycle: wr_en=1, wr_addr/wr_data = winner's fields, wr_src=winner, wr_is_clear=0;
  - rr_ptr = (winner+1) mod NUM_REQ.
- ARB with no handshake: wr_en=0; wr_addr/wr_data/wr_src hold their previous values; rr_ptr unchanged.
- Throughput: one write per cycle. Latency: handshake to wr_en = 1 cycle.
- Fairness: with all requesters continuously valid, grants rotate 0,1,2,3,0,...
- A requester may drop req_valid without a handshake; no state is kept for it.
- reset_n asserted mid-sweep or mid-arbitration: immediate return to reset values; a full sweep restarts after release.
- Width rules:
  - sweep_cnt is ADDR_W bits;
  - wr_src zero-extends the winner index to 3 bits;
  - CLEAR_VALUE is truncated to DATA_W.

Test Plan:
- Reset release, no requests → wr_en=1 in cycles 1..8 with wr_addr=0..7, wr_data=0, wr_is_clear=1; clear_busy=0 from cycle 8; wr_en=0 from cycle 9.
- After the sweep, requester 2 alone valid with addr=5, data=0xA5 → req_ready=0100 that cycle; next cycle wr_en=1, wr_addr=5, wr_data=0xA5, wr_src=2.
- All 4 requesters valid for 8 cycles → wr_src sequence 0,1,2,3,0,1,2,3; exactly one req_ready bit set per cycle.
- clear_req=1 in the same cycle as req_valid=0011 → req_ready=0000; 8 sweep writes follow; requester 0 is granted first afterwards (rr_ptr unchanged).
- clear_req held high through the sweep → exactly one sweep, then clear_req is sampled again in ARB and a second sweep starts.
- reset_n pulsed low at sweep write 4 → outputs return to reset values immediately; after release the sweep restarts at addr 0.
